// File: rtl/nibble_add_if.sv
// nibble_add_if: client request/operand bundle and result bundle of the nibble adder scheduler
interface nibble_add_if #(parameter int NIBBLES = 4);
  logic [1:0]           req;
  logic [4*NIBBLES-1:0] a0, b0, a1, b1;
  logic                 cin0, cin1;
  logic [1:0]           gnt, done;
  logic [4*NIBBLES-1:0] sum;
  logic                 cout, busy;
  modport master (output req, a0, b0, cin0, a1, b1, cin1, input gnt, done, sum, cout, busy);
  modport slave  (input req, a0, b0, cin0, a1, b1, cin1, output gnt, done, sum, cout, busy);
endinterface

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: round-robin two-client scheduler over one 4-bit adder, LSB nibble first
module nibble_add_sched #(parameter int NIBBLES = 4) (
  input logic clk,
  input logic rst_n,
  nibble_add_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [W-1:0]  a_q, b_q, res_q, sum_q, res_d;
  logic [KW-1:0] k_q;
  logic [1:0]    gnt_q, done_q;
  logic          carry_q, cout_q, busy_q, win_q, last_q, win_d;
  logic [4:0]    add_d;
  // operands shift right each cycle so the adder always sees the low nibble
  always_comb begin
    win_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    add_d = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
    res_d = W'({add_d[3:0], res_q} >> 4);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: if (|bus.req) begin
          a_q     <= win_d ? bus.a1 : bus.a0;
          b_q     <= win_d ? bus.b1 : bus.b0;
          carry_q <= win_d ? bus.cin1 : bus.cin0;
          res_q   <= '0;
          k_q     <= '0;
          win_q   <= win_d;
          last_q  <= win_d;
          gnt_q   <= win_d ? 2'b10 : 2'b01;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          res_q   <= res_d;
          carry_q <= add_d[4];
          k_q     <= k_q + KW'(1);
          if (k_q == KW'(NIBBLES - 1)) begin
            sum_q   <= res_d;
            cout_q  <= add_d[4];
            done_q  <= win_q ? 2'b10 : 2'b01;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: directed vectors with hand-computed results for NIBBLES=4
module tb_nibble_add_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  nibble_add_if #(.NIBBLES(4)) bus ();
  nibble_add_sched #(.NIBBLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_gnt(output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = (bus.gnt != 2'b00);
      n++;
    end
  endtask
  task automatic wait_done(output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = (bus.done != 2'b00);
      n++;
    end
  endtask
  task automatic op(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [15:0] s, input logic co, input bit poke);
    @(negedge clk);
    if (r[0]) begin
      bus.a0 = a; bus.b0 = b; bus.cin0 = c; bus.a1 = 16'hFFFF; bus.b1 = 16'hFFFF; bus.cin1 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.cin1 = c; bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF; bus.cin0 = 1'b1;
    end
    bus.req = r;
    @(negedge clk);
    chk("gnt", bus.gnt, r);
    chk("busy_c1", bus.busy, 1);
    bus.req = 2'b00;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (poke && i == 2) begin
        bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF; bus.cin0 = 1'b1;
        bus.a1 = 16'hFFFF; bus.b1 = 16'hFFFF; bus.cin1 = 1'b1;
      end
      chk("run_done", bus.done, 0);
      chk("run_busy", bus.busy, 1);
    end
    @(negedge clk);
    chk("done", bus.done, r);
    chk("sum", bus.sum, s);
    chk("cout", bus.cout, co);
    chk("busy_c5", bus.busy, 1);
    @(negedge clk);
    chk("busy_fall", bus.busy, 0);
    chk("done_fall", bus.done, 0);
    chk("sum_hold", bus.sum, s);
  endtask
  initial begin
    bit ok;
    int t;
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    op(2'b01, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 0);
    op(2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    op(2'b01, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 0);
    op(2'b10, 16'h0FF0, 16'h0010, 1'b0, 16'h1000, 1'b0, 0);
    op(2'b10, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
    op(2'b01, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1);
    // contention from a fresh reset: client 0 must win the first tie
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.a0 = 16'h0001; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
    bus.a1 = 16'h8000; bus.b1 = 16'h8000; bus.cin1 = 1'b0;
    bus.req = 2'b11;
    t = 0;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(ok);
      chk("c_gnt_seen", ok, 1);
      chk("c_gnt", bus.gnt, (i == 1) ? 2'b10 : 2'b01);
      if (i > 0) chk("c_space", cyc - t, 6);
      t = cyc;
      if (i == 2) bus.req = 2'b00;
      wait_done(ok);
      chk("c_done_seen", ok, 1);
      chk("c_done", bus.done, (i == 1) ? 2'b10 : 2'b01);
      chk("c_sum", bus.sum, (i == 1) ? 16'h0000 : 16'h0002);
      chk("c_cout", bus.cout, (i == 1) ? 1 : 0);
    end
    // reset in cycle 3 of an operation discards it
    @(negedge clk);
    @(negedge clk);
    bus.a0 = 16'h00FF; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
    bus.req = 2'b01;
    @(negedge clk);
    chk("r_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_gnt0", bus.gnt, 0);
    chk("r_done0", bus.done, 0);
    chk("r_sum0", bus.sum, 0);
    chk("r_cout0", bus.cout, 0);
    chk("r_busy0", bus.busy, 0);
    @(negedge clk);
    chk("r_done_hold", bus.done, 0);
    rst_n = 1'b1;
    bus.a1 = 16'h1111; bus.b1 = 16'h1111; bus.cin1 = 1'b0;
    bus.req = 2'b11;
    wait_gnt(ok);
    chk("r_gnt_seen", ok, 1);
    chk("r_first", bus.gnt, 2'b01);
    bus.req = 2'b00;
    wait_done(ok);
    chk("r_done_seen", ok, 1);
    chk("r_done", bus.done, 2'b01);
    chk("r_sum", bus.sum, 16'h0100);
    chk("r_cout", bus.cout, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
